// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access types, FSM states
// and the wait-counter width.
package dmem_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Codes above BYTE_U are unassigned and answered with an error.
  function automatic logic type_ok(input logic [2:0] t);
    return t <= DM_BYTE_U;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; unknown types produce no byte enables.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Select the addressed byte/half of the stored word, then steer per type.
  always_comb begin
    rbyte    = raw[{lane, 3'b000} +: 8];
    rhalf    = lane[1] ? raw[31:16] : raw[15:0];
    byte_en  = 4'b0000;
    wword    = wdata;
    rext     = '0;
    misalign = 1'b0;
    case (dm_type)
      DM_WORD: begin
        byte_en  = 4'b1111;
        rext     = raw;
        misalign = (lane != 2'b00);
      end
      DM_HALF, DM_HALF_U: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rext     = (dm_type == DM_HALF) ? {{16{rhalf[15]}}, rhalf} : {16'h0000, rhalf};
        misalign = lane[0];
      end
      DM_BYTE, DM_BYTE_U: begin
        byte_en  = 4'b0001 << lane;
        wword    = {4{wdata[7:0]}};
        rext     = (dm_type == DM_BYTE) ? {{24{rbyte[7]}}, rbyte} : {24'h000000, rbyte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, programmable wait states,
// lane-merged stores and extended loads, error on bad type/alignment/range.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int AW          = 7,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_type,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               accept;

  logic               lat_we;
  logic [31:0]        lat_addr;
  logic [31:0]        lat_wdata;
  logic [2:0]         lat_type;

  logic [31:0]        mem [DEPTH];
  logic [AW-1:0]      idx;
  logic [3:0]         byte_en;
  logic [31:0]        wword;
  logic [31:0]        rext;
  logic               misalign;
  logic               range_err;
  logic               acc_err;

  assign idx = lat_addr[AW+1:2];

  dmem_lane_align u_align (
    .dm_type  (lat_type),
    .lane     (lat_addr[1:0]),
    .wdata    (lat_wdata),
    .raw      (mem[idx]),
    .byte_en  (byte_en),
    .wword    (wword),
    .rext     (rext),
    .misalign (misalign)
  );

  // Range covers both a word index past DEPTH and any stray upper address bit.
  always_comb begin
    range_err = (lat_addr[31:AW+2] != '0) || ({{(32-AW){1'b0}}, idx} >= 32'(DEPTH));
    acc_err   = !type_ok(lat_type) || misalign || range_err;
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: accept only in IDLE, so the ready cycle never re-accepts.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_req) begin
          accept   = 1'b1;
          cnt_nx   = CNT_W'(WAIT_CYCLES);
          state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) state_nx = S_RESP;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Capture the request; later changes on the bus are ignored until IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_type  <= DM_WORD;
    end else if (accept) begin
      lat_we    <= mem_we;
      lat_addr  <= mem_addr;
      lat_wdata <= mem_wdata;
      lat_type  <= mem_type;
    end
  end

  // Storage is not reset; a store lands at the end of the RESP cycle.
  always_ff @(posedge clk) begin
    if (state == S_RESP && lat_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Response outputs exist only in RESP; stores and errors return zero data.
  always_comb begin
    mem_ready = (state == S_RESP);
    mem_err   = mem_ready && acc_err;
    mem_rdata = (mem_ready && !lat_we && !acc_err) ? rext : '0;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the pipeline CPU's MEM-stage load/store interface, replacing the zero-latency combinational dm.
- Accepts one request at a time over a req/ready handshake and holds the CPU via ready low.
- Inserts programmable wait states, performs byte/half/word stores with lane merging, and sign- or zero-extends loads.
- Flags misaligned and out-of-range accesses.

Parameters:
DEPTH, 128, number of 32-bit words stored; word index = addr[AW+1:2].
AW, 7, word-index width; must satisfy 2**AW >= DEPTH.
WAIT_CYCLES, 0, extra cycles between acceptance and response; 0..15.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  reset, asynchronous, active-low.
mem_req  in  1  request valid; held stable with its fields until mem_ready.
mem_we  in  1  1 = store, 0 = load.
mem_addr  in  32  byte address.
mem_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
mem_type  in  3  access type, DMType encoding (package).
mem_rdata  out  32  load result, extended; valid with mem_ready.
mem_ready  out  1  one-cycle completion pulse.
mem_err  out  1  error, valid with mem_ready.

Behaviour:
- Reset (rstn low, asynchronous):
  - State goes to IDLE; the wait counter clears.
  - mem_ready=0, mem_err=0, mem_rdata=0.
  - Storage contents are NOT cleared.
  - Reset mid-WAIT aborts the access; a pending store is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_req=1 latches we/addr/wdata/type and loads counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
- RESP:
  - mem_ready=1 for exactly one cycle, then IDLE.
  - A store commits in this cycle; load data is driven from the array in this cycle.
- Latency: mem_ready rises WAIT_CYCLES+1 cycles after the accepting edge.
- No re-acceptance in the ready cycle: the next request is sampled no earlier than the cycle after mem_ready. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- mem_req dropping during WAIT is a protocol violation; the latched access still completes.
- DMType encoding:
  - WORD=000, HALF=001, HALF_U=010, BYTE=011, BYTE_U=100.
  - Codes 101-111 raise an error.
- Alignment:
  - HALF/HALF_U need addr[0]=0.
  - WORD needs addr[1:0]=00.
- Range: word index >= DEPTH, or any of addr[31:AW+2] nonzero, raises an error.
- Error response: mem_err=1 and mem_rdata=0 alongside mem_ready; no storage write.
- Store lane merge:
  - BYTE writes lane addr[1:0] with wdata[7:0].
  - HALF writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - WORD writes all four lanes; other lanes are preserved.
  - _U types store identically to signed ones.
- Load extraction:
  - Select the lane(s) by addr[1:0].
  - BYTE/HALF sign-extend from bit 7/15; BYTE_U/HALF_U zero-extend.
  - A load's mem_rdata is 0 outside RESP; a store's mem_rdata is 0 in RESP.

Decomposition:
- Package dmem_pkg holds:
  - DMType localparams (DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U);
  - FSM state encoding (S_IDLE, S_WAIT, S_RESP);
  - the WAIT counter width (4).
- One sub-module, dmem_lane_align (combinational), produces:
  - byte-enable[3:0] and the shifted write word from (type, addr[1:0], wdata);
  - the extended load value from (type, addr[1:0], raw word);
  - the misalign flag.
- The top owns the FSM, the latches and the storage array.

Test Plan:
- WAIT_CYCLES=0: store WORD 0xDEADBEEF @0x10, then load WORD @0x10. Required: mem_ready exactly 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
- Byte/half lanes, after word 0xDEADBEEF @0x10:
  - store BYTE 0x5A @0x11, then load WORD @0x10 -> 0xDEAD5ABE... specifically 0xDEAD5AEF;
  - load BYTE @0x13 -> 0xFFFFFFDE;
  - load BYTE_U @0x13 -> 0x000000DE;
  - load HALF @0x12 -> 0xFFFFDEAD.
- Misalign: store HALF 0x1234 @0x21 -> err=1, rdata=0; then load WORD @0x20 returns the prior contents unchanged. Load WORD @0x22 -> err=1.
- Range and type: with DEPTH=128, load @0x200 -> err=1; mem_type=3'b111 -> err=1; no array change.
- WAIT_CYCLES=3 run:
  - mem_ready asserts 4 cycles after accept;
  - back-to-back requests complete every 5 cycles;
  - mem_ready is never asserted for 2 consecutive cycles.
- Reset mid-WAIT (WAIT_CYCLES=3): store WORD 0xCAFEF00D @0x40, pull rstn low for 1 cycle during WAIT. Required: ready/err/rdata go to 0 immediately; a subsequent load @0x40 returns the pre-store value.
